// File: rtl/sha512_digest_sequencer_if.sv
// Handshake bundle between the digest sequencer and the SHA-512 core.
// The master side issues the start pulse; the slave side returns done and the digest.
interface sha512_digest_sequencer_if #(
    parameter int DIGEST_W = 512
);
    logic                hash_start;
    logic                hash_done;
    logic [DIGEST_W-1:0] hash_digest;

    modport master (output hash_start, input hash_done, input hash_digest);
    modport slave  (input hash_start, output hash_done, output hash_digest);
endinterface

// File: rtl/sha512_digest_sequencer.sv
// Runs the SHA-512 core once per request, latches the digest and presents it
// as 32 words for the seven-segment driver, stepping by button or auto-scroll.
module sha512_digest_sequencer #(
    parameter int DIGEST_W     = 512,
    parameter int WORD_W       = 16,
    parameter int TIMEOUT      = 1024,
    parameter int SCROLL_TICKS = 500
) (
    input  logic                      sysclk_125mhz,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      restart,
    input  logic                      step,
    input  logic                      auto_en,
    sha512_digest_sequencer_if.master core,
    output logic [WORD_W-1:0]         word_out,
    output logic [4:0]                word_idx,
    output logic                      busy,
    output logic                      valid,
    output logic                      timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SCROLL_TICKS + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SLAST = SW'(SCROLL_TICKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    logic [2:0]          r_state;
    logic [TW-1:0]       r_timer;
    logic [SW-1:0]       r_scroll;
    logic [4:0]          r_idx;
    logic [WORD_W-1:0]   r_word;
    logic [DIGEST_W-1:0] r_digest;
    logic                r_step_s1, r_step_s2, r_step_d;

    logic [2:0]          w_state_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [SW-1:0]       w_scroll_nxt;
    logic [4:0]          w_idx_nxt;
    logic [WORD_W-1:0]   w_word_nxt;
    logic                w_adv;
    logic                w_step_pulse;

    assign w_step_pulse = r_step_s2 & ~r_step_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_scroll_nxt = r_scroll;
        w_idx_nxt    = r_idx;
        w_adv        = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nxt = S_START;
            S_START: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + 1'b1;
                if (core.hash_done)       w_state_nxt = S_CAPTURE;
                else if (r_timer == TLAST) w_state_nxt = S_ERROR;
            end
            S_CAPTURE: begin
                w_idx_nxt    = '0;
                w_scroll_nxt = '0;
                w_state_nxt  = S_SHOW;
            end
            S_SHOW: begin
                if (restart) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_START;
                end else begin
                    if (!auto_en) begin
                        w_scroll_nxt = '0;
                    end else if (tick) begin
                        if (r_scroll == SLAST) begin
                            w_scroll_nxt = '0;
                            w_adv        = 1'b1;
                        end else begin
                            w_scroll_nxt = r_scroll + 1'b1;
                        end
                    end
                    // a button press landing on the scroll tick still advances only once
                    if (w_step_pulse) w_adv = 1'b1;
                    if (w_adv)        w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_ERROR: if (restart) w_state_nxt = S_START;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (w_state_nxt)
            S_SHOW:  w_word_nxt = r_digest[WORD_W * 32'(w_idx_nxt) +: WORD_W];
            S_ERROR: w_word_nxt = {(WORD_W / 4){4'hE}};
            default: w_word_nxt = '0;
        endcase
    end

    // Digest is taken on the edge that sees hash_done, while the core guarantees it valid;
    // CAPTURE then only initialises the display so word 0 is ready on entry to SHOW.
    always_ff @(posedge sysclk_125mhz or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_scroll  <= '0;
            r_idx     <= '0;
            r_word    <= '0;
            r_digest  <= '0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
            r_step_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_scroll  <= w_scroll_nxt;
            r_idx     <= w_idx_nxt;
            r_word    <= w_word_nxt;
            r_step_s1 <= step;
            r_step_s2 <= r_step_s1;
            r_step_d  <= r_step_s2;
            if (r_state == S_WAIT && core.hash_done) r_digest <= core.hash_digest;
        end
    end

    assign core.hash_start = (r_state == S_START);
    assign busy            = (r_state == S_START) || (r_state == S_WAIT);
    assign valid           = (r_state == S_SHOW);
    assign timeout_err     = (r_state == S_ERROR);
    assign word_out        = r_word;
    assign word_idx        = r_idx;
endmodule

// File: tb/tb_sha512_digest_sequencer.sv
// Scoreboard bench: the core model and stimulus push expected display events,
// a negedge monitor pops and compares each event the sequencer presents.
module tb_sha512_digest_sequencer;
    localparam int TO  = 24;
    localparam int SCR = 3;
    localparam logic [511:0] D_EMPTY = 512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, restart = 1'b0, step = 1'b0, auto_en = 1'b0;
    logic [15:0] word_out;
    logic [4:0]  word_idx;
    logic        busy, valid, timeout_err;

    sha512_digest_sequencer_if #(.DIGEST_W(512)) cif ();

    sha512_digest_sequencer #(
        .DIGEST_W(512), .WORD_W(16), .TIMEOUT(TO), .SCROLL_TICKS(SCR)
    ) dut (
        .sysclk_125mhz(clk), .rst(rst), .tick(tick), .restart(restart), .step(step),
        .auto_en(auto_en), .core(cif.master), .word_out(word_out), .word_idx(word_idx),
        .busy(busy), .valid(valid), .timeout_err(timeout_err)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        int          cyc;
        logic [4:0]  idx;
        logic [15:0] word;
    } exp_t;
    exp_t q[$];

    int total = 0, bad = 0;
    int starts = 0, done_at = -1, core_lat = 20;
    logic [511:0] next_digest, m_digest;
    int m_idx = 0, m_ticks = 0;

    // Core model: answers each start after core_lat cycles (0 = never) and predicts the result.
    initial begin
        cif.hash_done   = 1'b0;
        cif.hash_digest = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                done_at       = -1;
                cif.hash_done = 1'b0;
            end else begin
                cif.hash_done = (cyc == done_at);
                if (cif.hash_start) begin
                    starts++;
                    if (core_lat == 0) begin
                        q.push_back('{err: 1'b1, cyc: cyc + TO + 1, idx: 5'd0, word: 16'hEEEE});
                    end else begin
                        done_at         = cyc + core_lat;
                        cif.hash_digest = next_digest;
                        m_digest        = next_digest;
                        m_idx           = 0;
                        m_ticks         = 0;
                        q.push_back('{err: 1'b0, cyc: cyc + core_lat + 2, idx: 5'd0,
                                      word: next_digest[15:0]});
                    end
                end
            end
        end
    end

    initial begin
        exp_t        e;
        logic        pv, pe, ps, ev_err, ev_show;
        logic [4:0]  pi;
        logic [15:0] pw;
        pv = 1'b0; pe = 1'b0; ps = 1'b0; pi = '0; pw = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0; pe = 1'b0; ps = 1'b0;
            end else begin
                total++;
                if (cif.hash_start && ps) begin
                    bad++;
                    $display("FAIL start_pulse_width: hash_start high two cycles at cyc %0d, required one", cyc);
                end
                ev_err  = timeout_err && !pe;
                ev_show = valid && (!pv || word_idx != pi || word_out != pw);
                if (ev_err || ev_show) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event: err=%0b idx=%0d word=%h at cyc %0d, required none",
                                 ev_err, word_idx, word_out, cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.err != ev_err || e.cyc != cyc || e.idx != word_idx || e.word != word_out) begin
                            bad++;
                            $display("FAIL display_event: got err=%0b cyc=%0d idx=%0d word=%h, required err=%0b cyc=%0d idx=%0d word=%h",
                                     ev_err, cyc, word_idx, word_out, e.err, e.cyc, e.idx, e.word);
                        end
                    end
                end
                pv = valid; pe = timeout_err; ps = cif.hash_start; pi = word_idx; pw = word_out;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic wait_drain(input string nm, input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            nxt();
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected events never appeared, required 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic wait_start(input string nm, input int s0, input int maxc);
        int n = 0;
        while (starts == s0 && n < maxc) begin
            nxt();
            n++;
        end
        chk(nm, starts, s0 + 1);
    endtask

    task automatic advance(input int at_cyc);
        m_idx = (m_idx + 1) % 32;
        q.push_back('{err: 1'b0, cyc: at_cyc, idx: 5'(m_idx), word: m_digest[m_idx*16 +: 16]});
    endtask

    task automatic press_step(input bit with_tick);
        advance(cyc + 3);
        if (with_tick) m_ticks = 0;
        step = 1'b1;
        nxt(); nxt();
        if (with_tick) tick = 1'b1;
        nxt();
        tick = 1'b0;
        nxt();
        step = 1'b0;
        repeat ($urandom_range(3, 6)) nxt();
    endtask

    task automatic tick_pulse();
        if (auto_en) begin
            m_ticks++;
            if (m_ticks == SCR) begin
                m_ticks = 0;
                advance(cyc + 1);
            end
        end
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        repeat (9) nxt();
    endtask

    function automatic logic [511:0] rand_digest();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        int s0;
        next_digest = D_EMPTY;
        core_lat    = 20;
        repeat (3) nxt();
        chk("reset_word_out", word_out, 0);
        chk("reset_word_idx", word_idx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_timeout_err", timeout_err, 0);
        chk("reset_hash_start", cif.hash_start, 0);

        // first run after reset release
        rst = 1'b1;
        wait_start("first_start", 0, 10);
        wait_drain("first_show", 60);
        chk("single_start", starts, 1);

        // manual stepping through every word and past the wrap
        repeat (33) press_step(1'b0);
        wait_drain("step_walk", 50);
        chk("idx_after_33", word_idx, 32'(m_idx));

        // ticks with auto-scroll off must not move or pre-load the scroll count
        repeat (4) tick_pulse();
        auto_en = 1'b1;
        m_ticks = 0;
        repeat (8) tick_pulse();
        press_step(1'b1);
        repeat (3) tick_pulse();
        wait_drain("auto_scroll", 50);

        // randomized mix of presses, ticks and auto-scroll enable changes
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: press_step(1'b0);
                1: begin
                    auto_en = ~auto_en;
                    if (!auto_en) m_ticks = 0;
                    nxt();
                end
                default: tick_pulse();
            endcase
        end
        wait_drain("random_mix", 50);
        auto_en = 1'b0;
        nxt();

        // core never answers: timeout
        core_lat    = 0;
        next_digest = rand_digest();
        s0 = starts;
        restart = 1'b1; nxt(); restart = 1'b0;
        chk("restart_from_show", starts, s0 + 1);
        chk("valid_drops", valid, 0);
        wait_drain("timeout", TO + 20);
        chk("err_flag", timeout_err, 1);
        chk("err_word", word_out, 16'hEEEE);
        chk("err_valid", valid, 0);

        // done on the last allowed cycle; restart inside WAIT is ignored
        core_lat    = TO;
        next_digest = rand_digest();
        s0 = starts;
        restart = 1'b1; nxt(); restart = 1'b0;
        chk("restart_from_error", starts, s0 + 1);
        chk("err_cleared", timeout_err, 0);
        repeat (5) nxt();
        chk("busy_in_wait", busy, 1);
        restart = 1'b1; nxt(); restart = 1'b0;
        wait_drain("done_at_limit", TO + 20);
        chk("restart_in_wait_ignored", starts, s0 + 1);
        chk("valid_after_limit", valid, 1);
        chk("no_err_at_limit", timeout_err, 0);

        // reset asserted mid-WAIT aborts; release gives one fresh start
        core_lat    = $urandom_range(6, 15);
        next_digest = rand_digest();
        restart = 1'b1; nxt(); restart = 1'b0;
        repeat (4) nxt();
        chk("busy_before_abort", busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_word", word_out, 0);
        chk("abort_start", cif.hash_start, 0);
        q.delete();
        nxt(); nxt();
        s0 = starts;
        rst = 1'b1;
        wait_start("start_after_abort", s0, 10);
        wait_drain("show_after_abort", 60);
        repeat (5) nxt();
        chk("single_start_after_abort", starts, s0 + 1);

        repeat (3) press_step(1'b0);
        wait_drain("final_steps", 50);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
